// File: rtl/clk_divider_bank_if.sv
// Configuration write bus for clk_divider_bank: a strobe-only write port
// with registered acknowledge/error responses.
interface clk_divider_bank_if #(
    parameter int CHW = 2,
    parameter int CW  = 32
) ();
    // Handshake: cfg_valid is a one-cycle write strobe with no ready. Every
    // strobe is consumed on the rising edge where it is high, and one write
    // per cycle is allowed. Exactly one of cfg_ack (target channel exists) or
    // cfg_err (target channel out of range) is high in the cycle after each
    // strobe.
    logic           cfg_valid;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_mode;
    logic           cfg_restart;
    logic           cfg_ack;
    logic           cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_mode, cfg_restart,
        input  cfg_ack, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_mode, cfg_restart,
        output cfg_ack, cfg_err
    );
endinterface

// File: rtl/clk_divider_bank.sv
// Bank of NCH independent programmable clock dividers with shadowed
// divisor/mode registers applied at terminal count or immediately on restart.
module clk_divider_bank #(
    parameter int NCH         = 4,
    parameter int CW          = 32,
    parameter int DEFAULT_DIV = 50_000_000,
    parameter int CHW         = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           en,
    clk_divider_bank_if.slave        cfg,
    output logic [NCH-1:0]           clk_out,
    output logic [NCH-1:0]           tick,
    output logic [NCH-1:0]           pending
);

    localparam logic [CW-1:0] RESET_DIV = CW'(DEFAULT_DIV);

    logic [CW-1:0]  cnt      [NCH];
    logic [CW-1:0]  div_act  [NCH];
    logic [CW-1:0]  div_sh   [NCH];
    logic [NCH-1:0] mode_act;
    logic [NCH-1:0] mode_sh;

    logic           ch_ok;
    logic [NCH-1:0] wr_hit;
    logic [NCH-1:0] term;

    // An out-of-range channel index simply matches no channel, so such a
    // write leaves every channel untouched and only raises cfg_err.
    always_comb begin
        ch_ok  = 32'(cfg.cfg_ch) < NCH;
        wr_hit = '0;
        term   = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = cfg.cfg_valid && (cfg.cfg_ch == CHW'(i));
            term[i]   = en[i] && (cnt[i] == div_act[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg.cfg_ack <= 1'b0;
            cfg.cfg_err <= 1'b0;
        end else begin
            cfg.cfg_ack <= cfg.cfg_valid && ch_ok;
            cfg.cfg_err <= cfg.cfg_valid && !ch_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i]     <= '0;
                div_act[i] <= RESET_DIV;
                div_sh[i]  <= RESET_DIV;
            end
            mode_act <= '0;
            mode_sh  <= '0;
            pending  <= '0;
            clk_out  <= '0;
            tick     <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_hit[i] && cfg.cfg_restart) begin
                    // Immediate apply wins over a coincident terminal count.
                    div_act[i]  <= cfg.cfg_div;
                    mode_act[i] <= cfg.cfg_mode;
                    cnt[i]      <= '0;
                    clk_out[i]  <= 1'b0;
                    tick[i]     <= 1'b0;
                    pending[i]  <= 1'b0;
                end else begin
                    if (term[i]) begin
                        cnt[i]     <= '0;
                        tick[i]    <= 1'b1;
                        clk_out[i] <= mode_act[i] ? 1'b1 : ~clk_out[i];
                        if (pending[i]) begin
                            div_act[i]  <= div_sh[i];
                            mode_act[i] <= mode_sh[i];
                            pending[i]  <= 1'b0;
                        end
                    end else if (en[i]) begin
                        // Wraps naturally at 2**CW-1 if cnt ever exceeds div_act.
                        cnt[i]  <= cnt[i] + CW'(1);
                        tick[i] <= 1'b0;
                        if (mode_act[i]) begin
                            clk_out[i] <= 1'b0;
                        end
                    end else begin
                        tick[i] <= 1'b0;
                    end

                    // Placed after the terminal-count load so a coincident
                    // deferred write lands in the shadow and stays pending.
                    if (wr_hit[i]) begin
                        div_sh[i]  <= cfg.cfg_div;
                        mode_sh[i] <= cfg.cfg_mode;
                        pending[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank: a cycle-by-cycle vector table plus
// hand-written sequences for enable freeze and mid-count reset.
module tb_clk_divider_bank;

    localparam int NCH   = 4;
    localparam int CW    = 8;
    localparam int CHW   = 3;
    localparam int DDIV  = 10;

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] en;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pending;

    int checks;
    int errors;

    clk_divider_bank_if #(.CHW(CHW), .CW(CW)) cfg_bus ();

    clk_divider_bank #(
        .NCH(NCH), .CW(CW), .DEFAULT_DIV(DDIV), .CHW(CHW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .cfg     (cfg_bus.slave),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [NCH-1:0] en;
        logic           valid;
        logic [CHW-1:0] ch;
        logic [CW-1:0]  div;
        logic           mode;
        logic           restart;
        logic [NCH-1:0] exp_clk;
        logic [NCH-1:0] exp_tick;
        logic [NCH-1:0] exp_pend;
        logic           exp_ack;
        logic           exp_err;
    } vec_t;

    vec_t tbl [32];
    logic [1:0] exp_q [$];
    logic       en_seq [$];

    function automatic vec_t wr(input logic [3:0] e, input int ch, input int dv,
                                input logic md, input logic rs, input logic [3:0] c,
                                input logic [3:0] t, input logic [3:0] p,
                                input logic a, input logic er);
        vec_t v;
        v.en = e; v.valid = 1'b1; v.ch = CHW'(ch); v.div = CW'(dv);
        v.mode = md; v.restart = rs;
        v.exp_clk = c; v.exp_tick = t; v.exp_pend = p; v.exp_ack = a; v.exp_err = er;
        return v;
    endfunction

    function automatic vec_t idle(input logic [3:0] e, input logic [3:0] c,
                                  input logic [3:0] t, input logic [3:0] p);
        vec_t v;
        v = wr(e, 0, 0, 1'b0, 1'b0, c, t, p, 1'b0, 1'b0);
        v.valid = 1'b0;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_cfg(input logic v, input int ch, input int dv,
                             input logic md, input logic rs);
        cfg_bus.cfg_valid   = v;
        cfg_bus.cfg_ch      = CHW'(ch);
        cfg_bus.cfg_div     = CW'(dv);
        cfg_bus.cfg_mode    = md;
        cfg_bus.cfg_restart = rs;
    endtask

    initial begin
        int first_tick;
        string nm;
        logic [1:0] e;

        checks = 0;
        errors = 0;

        // Main sequence: D=3 toggle on ch0, deferred D=1, bad channel,
        // pulse D=0 on ch2, restart vs terminal, write vs terminal.
        tbl[0]  = wr  (4'b0001, 0, 3, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
        tbl[1]  = idle(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tbl[2]  = idle(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tbl[3]  = idle(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tbl[4]  = idle(4'b0001, 4'b0001, 4'b0001, 4'b0000);
        tbl[5]  = idle(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        tbl[6]  = idle(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        tbl[7]  = idle(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        tbl[8]  = idle(4'b0001, 4'b0000, 4'b0001, 4'b0000);
        tbl[9]  = idle(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tbl[10] = wr  (4'b0001, 0, 1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0);
        tbl[11] = idle(4'b0001, 4'b0000, 4'b0000, 4'b0001);
        tbl[12] = idle(4'b0001, 4'b0001, 4'b0001, 4'b0000);
        tbl[13] = idle(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        tbl[14] = idle(4'b0001, 4'b0000, 4'b0001, 4'b0000);
        tbl[15] = idle(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tbl[16] = idle(4'b0001, 4'b0001, 4'b0001, 4'b0000);
        tbl[17] = wr  (4'b0001, 5, 7, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1);
        tbl[18] = idle(4'b0001, 4'b0000, 4'b0001, 4'b0000);
        tbl[19] = wr  (4'b0101, 2, 0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
        tbl[20] = idle(4'b0101, 4'b0101, 4'b0101, 4'b0000);
        tbl[21] = idle(4'b0101, 4'b0101, 4'b0100, 4'b0000);
        tbl[22] = idle(4'b0101, 4'b0100, 4'b0101, 4'b0000);
        tbl[23] = idle(4'b0101, 4'b0100, 4'b0100, 4'b0000);
        tbl[24] = wr  (4'b0101, 0, 1, 1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0);
        tbl[25] = idle(4'b0101, 4'b0100, 4'b0100, 4'b0000);
        tbl[26] = wr  (4'b0101, 0, 2, 1'b1, 1'b0, 4'b0101, 4'b0101, 4'b0001, 1'b1, 1'b0);
        tbl[27] = idle(4'b0101, 4'b0101, 4'b0100, 4'b0001);
        tbl[28] = idle(4'b0101, 4'b0100, 4'b0101, 4'b0000);
        tbl[29] = idle(4'b0101, 4'b0100, 4'b0100, 4'b0000);
        tbl[30] = idle(4'b0101, 4'b0100, 4'b0100, 4'b0000);
        tbl[31] = idle(4'b0101, 4'b0101, 4'b0101, 4'b0000);

        rst_n = 1'b0;
        en    = '0;
        drive_cfg(1'b0, 0, 0, 1'b0, 1'b0);
        step();
        step();
        chk("reset clk_out", 32'(clk_out), 0);
        chk("reset tick", 32'(tick), 0);
        chk("reset pending", 32'(pending), 0);
        chk("reset ack", 32'(cfg_bus.cfg_ack), 0);
        chk("reset err", 32'(cfg_bus.cfg_err), 0);

        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            en = tbl[r].en;
            drive_cfg(tbl[r].valid, int'(tbl[r].ch), int'(tbl[r].div),
                      tbl[r].mode, tbl[r].restart);
            step();
            nm = $sformatf("row%0d", r);
            chk({nm, " clk_out"}, 32'(clk_out), 32'(tbl[r].exp_clk));
            chk({nm, " tick"}, 32'(tick), 32'(tbl[r].exp_tick));
            chk({nm, " pending"}, 32'(pending), 32'(tbl[r].exp_pend));
            chk({nm, " ack"}, 32'(cfg_bus.cfg_ack), 32'(tbl[r].exp_ack));
            chk({nm, " err"}, 32'(cfg_bus.cfg_err), 32'(tbl[r].exp_err));
        end

        // Enable freeze on ch1 (D=2, toggle): expected {tick, clk_out} per edge.
        en = 4'b0010;
        drive_cfg(1'b1, 1, 2, 1'b0, 1'b1);
        step();
        drive_cfg(1'b0, 0, 0, 1'b0, 1'b0);
        chk("freeze restart clk1", 32'(clk_out[1]), 0);
        en_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_q  = '{2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                   2'b01, 2'b10, 2'b00};
        for (int k = 0; k < 12; k++) begin
            en[1] = en_seq.pop_front();
            step();
            e = exp_q.pop_front();
            chk($sformatf("freeze%0d tick1", k), 32'(tick[1]), 32'(e[1]));
            chk($sformatf("freeze%0d clk1", k), 32'(clk_out[1]), 32'(e[0]));
        end

        // Reset mid-count with a pending write, and a write on the reset edge.
        en = 4'b0001;
        drive_cfg(1'b1, 0, 5, 1'b0, 1'b1);
        step();
        drive_cfg(1'b0, 0, 0, 1'b0, 1'b0);
        step();
        step();
        drive_cfg(1'b1, 0, 1, 1'b0, 1'b0);
        step();
        chk("prereset pending", 32'(pending), 32'h1);
        rst_n = 1'b0;
        en    = 4'b1111;
        drive_cfg(1'b1, 0, 3, 1'b1, 1'b1);
        step();
        chk("midreset clk_out", 32'(clk_out), 0);
        chk("midreset tick", 32'(tick), 0);
        chk("midreset pending", 32'(pending), 0);
        chk("midreset ack", 32'(cfg_bus.cfg_ack), 0);
        rst_n = 1'b1;
        drive_cfg(1'b0, 0, 0, 1'b0, 1'b0);
        first_tick = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (tick[0]) begin
                first_tick = n;
                break;
            end
        end
        chk("first tick after reset", 32'(first_tick), DDIV + 1);
        chk("tick all channels", 32'(tick), 32'hF);
        chk("clk_out all channels", 32'(clk_out), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_divider_bank.md
CLK_DIVIDER_BANK -- requirements
Module: clk_divider_bank

Interface
REQ-001 Parameter NCH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CW, default 32, width of each channel's counter and divisor.
REQ-003 Parameter DEFAULT_DIV, default 50_000_000, divisor loaded into every channel at reset (must fit in CW bits).
REQ-004 Parameter CHW, default 2, width of cfg_ch; CHW SHALL satisfy 2**CHW >= NCH.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 en  input  NCH  per-channel count enable.
REQ-008 cfg_valid  input  1  configuration write strobe, one write per cycle.
REQ-009 cfg_ch  input  CHW  target channel index.
REQ-010 cfg_div  input  CW  new divisor D.
REQ-011 cfg_mode  input  1  new mode: 0 = toggle (square wave), 1 = pulse.
REQ-012 cfg_restart  input  1  1 = apply immediately, 0 = apply at next terminal count.
REQ-013 clk_out  output  NCH  per-channel divided output, registered.
REQ-014 tick  output  NCH  per-channel one-cycle terminal-count strobe, registered.
REQ-015 pending  output  NCH  per-channel flag: shadow configuration awaiting terminal count.
REQ-016 cfg_ack  output  1  registered, high one cycle after an accepted write.
REQ-017 cfg_err  output  1  registered, high one cycle after a write with cfg_ch >= NCH.

Function
REQ-018 Each channel SHALL hold cnt[CW], div_act[CW], mode_act, div_sh[CW], mode_sh, pending.
REQ-019 Terminal count: on an edge with en[i]=1 and cnt==div_act, the channel SHALL set cnt<=0 and tick<=1.
REQ-020 Terminal count with mode_act=0 SHALL toggle clk_out[i]; with mode_act=1 it SHALL set clk_out[i]<=1.
REQ-021 Terminal count with pending=1 SHALL load div_act<=div_sh and mode_act<=mode_sh, and clear pending.
REQ-022 Non-terminal edge with en[i]=1 SHALL increment cnt and set tick<=0.
REQ-023 Non-terminal edge with en[i]=1 and mode_act=1 SHALL set clk_out[i]<=0; mode_act=0 holds clk_out.
REQ-024 With en[i] held high: tick period = D+1 cycles; toggle-mode clk_out period = 2*(D+1) cycles at 50% duty; pulse-mode clk_out is identical to tick.
REQ-025 D=0 SHALL be legal: tick high every cycle, toggle-mode clk_out = clk/2.
REQ-026 en[i]=0 SHALL freeze cnt and clk_out[i], force tick[i]<=0, and keep pending/shadow unchanged.
REQ-027 Accepted write, cfg_restart=0: div_sh<=cfg_div, mode_sh<=cfg_mode, pending<=1; a later write before terminal count overwrites the shadow.
REQ-028 Accepted write, cfg_restart=1: div_act<=cfg_div, mode_act<=cfg_mode, cnt<=0, clk_out<=0, tick<=0, pending<=0, regardless of en.
REQ-029 Write and terminal count in the same cycle, restart=0: terminal count uses the prior div_act/shadow state; afterwards the new write occupies the shadow and pending=1.
REQ-030 Write and terminal count in the same cycle, restart=1: restart SHALL win and tick SHALL stay 0.
REQ-031 A write with cfg_ch >= NCH SHALL change no channel state and SHALL pulse cfg_err, not cfg_ack.
REQ-032 If cnt > div_act, the counter SHALL count up and wrap at 2**CW-1 to 0 with no tick; this can occur only through an out-of-range divisor.
REQ-033 Channels SHALL be fully independent; configuring one channel SHALL NOT disturb another channel.

Reset
REQ-034 While rst_n=0 at a rising edge: all cnt<=0, div_act<=div_sh<=DEFAULT_DIV, mode_act<=mode_sh<=0.
REQ-035 While rst_n=0 at a rising edge: pending, clk_out, tick, cfg_ack and cfg_err SHALL all be 0.
REQ-036 Reset SHALL override any concurrent write or terminal count; a mid-count reset discards the count.
REQ-037 Counting SHALL resume on the first edge with rst_n=1.

Verification
REQ-038 Reset, en=4'b0001, restart write ch0 D=3 mode0 -> tick[0] every 4 cycles; clk_out[0] period 8 cycles; ch1-3 clk_out stay 0.
REQ-039 ch0 running D=3; write D=1 restart=0 mid-period -> pending[0]=1; old period completes; then tick every 2 cycles; pending clears at the terminal count.
REQ-040 Restart write ch2 D=0 mode1, en[2]=1 -> tick[2]=clk_out[2]=1 every cycle; cfg_ack high for one cycle.
REQ-041 Write cfg_ch=5 with NCH=4 -> cfg_err pulses once; no output, pending or counter changes.
REQ-042 ch1 D=2 running; drop en[1] for 5 cycles -> clk_out[1] holds, tick[1]=0; phase resumes exactly where it stopped.
REQ-043 Assert rst_n=0 mid-count with a pending write -> all outputs 0 and pending cleared; after release with en=1, tick[0] first at cycle DEFAULT_DIV+1.
